// File: rtl/frame_pkg.sv
// Shared types and defaults for the transmit frame sequencer.
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREAMB = 2'd1,
        DATA   = 2'd2,
        GAP    = 2'd3
    } frame_state_e;

    localparam int unsigned PREAMB_LEN_DEF = 320;
    localparam int unsigned SYM_LEN_DEF    = 80;
    localparam int unsigned GAP_LEN_DEF    = 16;
    localparam int unsigned NSYM_W_DEF     = 8;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Request/control bundle between the frame requester and the frame sequencer.
interface frame_sequencer_if #(
    parameter int unsigned NSYM_W = 8
);
    logic              enable;
    logic              ready_in;
    logic              start;
    logic [NSYM_W-1:0] num_sym;
    logic              mod_switch_in;

    logic              busy;
    logic              preamb_en;
    logic              ofdm_en;
    logic              sel_preamb;
    logic              mod_switch_out;
    logic [NSYM_W-1:0] sym_idx;
    logic              sop;
    logic              eop;
    logic              frame_done;

    modport master (
        output enable, ready_in, start, num_sym, mod_switch_in,
        input  busy, preamb_en, ofdm_en, sel_preamb, mod_switch_out, sym_idx, sop, eop,
               frame_done
    );

    modport slave (
        input  enable, ready_in, start, num_sym, mod_switch_in,
        output busy, preamb_en, ofdm_en, sel_preamb, mod_switch_out, sym_idx, sop, eop,
               frame_done
    );
endinterface

// File: rtl/stall_counter.sv
// Modulo counter that wraps after the programmed last value; only moves on advance.
module stall_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             adv,
    input  logic             clear,
    input  logic [Width-1:0] last,
    output logic [Width-1:0] count,
    output logic             tc
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (adv) begin
            count_q <= tc ? '0 : count_q + Width'(1);
        end
    end

    assign count = count_q;
    assign tc    = (count_q == last);

endmodule

// File: rtl/frame_sequencer.sv
// Start-triggered frame scheduler: preamble, N OFDM symbols, then an idle gap.
module frame_sequencer
    import frame_pkg::*;
#(
    parameter int unsigned PREAMB_LEN = PREAMB_LEN_DEF,
    parameter int unsigned SYM_LEN    = SYM_LEN_DEF,
    parameter int unsigned GAP_LEN    = GAP_LEN_DEF,
    parameter int unsigned NSYM_W     = NSYM_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    frame_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(max3(PREAMB_LEN, SYM_LEN, GAP_LEN));
    localparam logic [CntW-1:0] PreambLast = CntW'(PREAMB_LEN - 1);
    localparam logic [CntW-1:0] SymLast    = CntW'(SYM_LEN - 1);
    localparam logic [CntW-1:0] GapLast    = CntW'(GAP_LEN - 1);

    frame_state_e      state_q, state_d;
    logic              adv;
    logic              launch;
    logic [CntW-1:0]   smp_cnt;
    logic [CntW-1:0]   smp_last;
    logic              smp_tc;
    logic [NSYM_W-1:0] sym_cnt_q;
    logic [NSYM_W-1:0] nsym_q;
    logic              mod_q;
    logic              pending_q;
    logic [NSYM_W-1:0] shadow_nsym_q;
    logic              shadow_mod_q;
    logic              frame_done_q;
    logic              last_sym;

    logic              busy, preamb_en, ofdm_en, sel_preamb, sop, eop;

    assign adv      = bus.enable & bus.ready_in;
    assign launch   = (state_q == IDLE) & bus.enable & (bus.start | pending_q);
    assign last_sym = (sym_cnt_q == nsym_q - NSYM_W'(1));

    always_comb begin
        smp_last = '0;
        unique case (state_q)
            PREAMB:  smp_last = PreambLast;
            DATA:    smp_last = SymLast;
            GAP:     smp_last = GapLast;
            default: smp_last = '0;
        endcase
    end

    // Held at zero while idle so every frame starts its preamble from sample 0.
    stall_counter #(
        .Width(CntW)
    ) u_smp_cnt (
        .clock(clock),
        .reset(reset),
        .adv  (adv),
        .clear(state_q == IDLE),
        .last (smp_last),
        .count(smp_cnt),
        .tc   (smp_tc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (launch) state_d = PREAMB;
            end
            PREAMB: begin
                if (adv && smp_tc) state_d = (nsym_q != '0) ? DATA : GAP;
            end
            DATA: begin
                if (adv && smp_tc && last_sym) state_d = GAP;
            end
            GAP: begin
                if (adv && smp_tc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        preamb_en  = (state_q == PREAMB);
        ofdm_en    = (state_q == DATA);
        sel_preamb = (state_q != DATA);
        sop        = (state_q == PREAMB) && (smp_cnt == '0);
        eop        = ((state_q == DATA) && last_sym && smp_tc) ||
                     ((state_q == PREAMB) && smp_tc && (nsym_q == '0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sym_cnt_q     <= '0;
            nsym_q        <= '0;
            mod_q         <= 1'b0;
            pending_q     <= 1'b0;
            shadow_nsym_q <= '0;
            shadow_mod_q  <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= (state_q == GAP) && adv && smp_tc;
            if (launch) begin
                nsym_q    <= pending_q ? shadow_nsym_q : bus.num_sym;
                mod_q     <= pending_q ? shadow_mod_q : bus.mod_switch_in;
                pending_q <= 1'b0;
            end else if (bus.enable && bus.start && (state_q != IDLE)) begin
                // One-deep: a later request simply overwrites the shadow copy.
                pending_q     <= 1'b1;
                shadow_nsym_q <= bus.num_sym;
                shadow_mod_q  <= bus.mod_switch_in;
            end
            if ((state_q == DATA) && adv && smp_tc) begin
                sym_cnt_q <= last_sym ? '0 : sym_cnt_q + NSYM_W'(1);
            end
        end
    end

    assign bus.busy           = busy;
    assign bus.preamb_en      = preamb_en;
    assign bus.ofdm_en        = ofdm_en;
    assign bus.sel_preamb     = sel_preamb;
    assign bus.mod_switch_out = mod_q;
    assign bus.sym_idx        = sym_cnt_q;
    assign bus.sop            = sop;
    assign bus.eop            = eop;
    assign bus.frame_done     = frame_done_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed, table-driven bench for frame_sequencer with small frame lengths.
module tb_frame_sequencer;

    localparam int unsigned PL = 4;
    localparam int unsigned SL = 3;
    localparam int unsigned GL = 2;
    localparam int unsigned NW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    frame_sequencer_if #(.NSYM_W(NW)) bus ();

    frame_sequencer #(
        .PREAMB_LEN(PL),
        .SYM_LEN   (SL),
        .GAP_LEN   (GL),
        .NSYM_W    (NW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Output word: busy preamb_en ofdm_en sel_preamb mod_out sym_idx[3:0] sop eop frame_done
    typedef struct packed {
        logic          en;
        logic          rdy;
        logic          st;
        logic [NW-1:0] ns;
        logic          md;
        logic [11:0]   exp;
    } vec_t;

    vec_t vq[$];

    function automatic logic [11:0] outs();
        return {bus.busy, bus.preamb_en, bus.ofdm_en, bus.sel_preamb, bus.mod_switch_out,
                bus.sym_idx, bus.sop, bus.eop, bus.frame_done};
    endfunction

    function automatic logic [11:0] e_idle(logic m, logic fd);
        return {1'b0, 1'b0, 1'b0, 1'b1, m, 4'd0, 1'b0, 1'b0, fd};
    endfunction

    function automatic logic [11:0] e_pre(logic m, logic s, logic e);
        return {1'b1, 1'b1, 1'b0, 1'b1, m, 4'd0, s, e, 1'b0};
    endfunction

    function automatic logic [11:0] e_dat(logic m, logic [3:0] i, logic e);
        return {1'b1, 1'b0, 1'b1, 1'b0, m, i, 1'b0, e, 1'b0};
    endfunction

    function automatic logic [11:0] e_gap(logic m);
        return {1'b1, 1'b0, 1'b0, 1'b1, m, 4'd0, 1'b0, 1'b0, 1'b0};
    endfunction

    task automatic check_vec(input string name, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b (busy pre ofdm sel mod idx sop eop done)",
                     name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic add(input logic en, input logic rdy, input logic st, input logic [NW-1:0] ns,
                       input logic md, input logic [11:0] exp);
        vq.push_back({en, rdy, st, ns, md, exp});
    endtask

    task automatic step(input logic [11:0] exp);
        add(1'b1, 1'b1, 1'b0, '0, 1'b0, exp);
    endtask

    task automatic strt(input logic [NW-1:0] ns, input logic md, input logic [11:0] exp);
        add(1'b1, 1'b1, 1'b1, ns, md, exp);
    endtask

    task automatic rdy(input logic r, input logic [11:0] exp);
        add(1'b1, r, 1'b0, '0, 1'b0, exp);
    endtask

    task automatic drive(input logic en, input logic r, input logic st, input logic [NW-1:0] ns,
                         input logic md);
        bus.enable        = en;
        bus.ready_in      = r;
        bus.start         = st;
        bus.num_sym       = ns;
        bus.mod_switch_in = md;
    endtask

    initial begin
        int data_cnt;
        int eop_cnt;
        int max_idx;
        int done_seen;
        int reached;

        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Nominal frame, two symbols
        strt(4'd2, 1'b0, e_pre(1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) step(e_pre(1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) step(e_dat(1'b0, 4'd0, 1'b0));
        step(e_dat(1'b0, 4'd1, 1'b0));
        step(e_dat(1'b0, 4'd1, 1'b0));
        step(e_dat(1'b0, 4'd1, 1'b1));
        step(e_gap(1'b0));
        step(e_gap(1'b0));
        step(e_idle(1'b0, 1'b1));
        step(e_idle(1'b0, 1'b0));

        // ready_in stalls during DATA (pattern 1,0,0,...), eop held through stall
        strt(4'd2, 1'b1, e_pre(1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) step(e_pre(1'b1, 1'b0, 1'b0));
        step(e_dat(1'b1, 4'd0, 1'b0));
        rdy(1'b1, e_dat(1'b1, 4'd0, 1'b0));
        rdy(1'b0, e_dat(1'b1, 4'd0, 1'b0));
        rdy(1'b0, e_dat(1'b1, 4'd0, 1'b0));
        rdy(1'b1, e_dat(1'b1, 4'd0, 1'b0));
        rdy(1'b0, e_dat(1'b1, 4'd0, 1'b0));
        rdy(1'b0, e_dat(1'b1, 4'd0, 1'b0));
        rdy(1'b1, e_dat(1'b1, 4'd1, 1'b0));
        rdy(1'b0, e_dat(1'b1, 4'd1, 1'b0));
        rdy(1'b0, e_dat(1'b1, 4'd1, 1'b0));
        rdy(1'b1, e_dat(1'b1, 4'd1, 1'b0));
        rdy(1'b0, e_dat(1'b1, 4'd1, 1'b0));
        rdy(1'b0, e_dat(1'b1, 4'd1, 1'b0));
        rdy(1'b1, e_dat(1'b1, 4'd1, 1'b1));
        rdy(1'b0, e_dat(1'b1, 4'd1, 1'b1));
        rdy(1'b0, e_dat(1'b1, 4'd1, 1'b1));
        step(e_gap(1'b1));
        step(e_gap(1'b1));
        step(e_idle(1'b1, 1'b1));
        step(e_idle(1'b1, 1'b0));

        // Preamble-only frame
        strt(4'd0, 1'b0, e_pre(1'b0, 1'b1, 1'b0));
        step(e_pre(1'b0, 1'b0, 1'b0));
        step(e_pre(1'b0, 1'b0, 1'b0));
        step(e_pre(1'b0, 1'b0, 1'b1));
        step(e_gap(1'b0));
        step(e_gap(1'b0));
        step(e_idle(1'b0, 1'b1));
        step(e_idle(1'b0, 1'b0));

        // Start while busy: second frame queued, launched the cycle after IDLE
        strt(4'd1, 1'b0, e_pre(1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) step(e_pre(1'b0, 1'b0, 1'b0));
        step(e_dat(1'b0, 4'd0, 1'b0));
        strt(4'd3, 1'b1, e_dat(1'b0, 4'd0, 1'b0));
        step(e_dat(1'b0, 4'd0, 1'b1));
        step(e_gap(1'b0));
        step(e_gap(1'b0));
        step(e_idle(1'b0, 1'b1));
        step(e_pre(1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) step(e_pre(1'b1, 1'b0, 1'b0));
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 3; k++) step(e_dat(1'b1, 4'(s), (s == 2) && (k == 2)));
        end
        step(e_gap(1'b1));
        step(e_gap(1'b1));
        step(e_idle(1'b1, 1'b1));
        step(e_idle(1'b1, 1'b0));

        // enable low mid-PREAMB freezes everything and drops start pulses
        strt(4'd0, 1'b0, e_pre(1'b0, 1'b1, 1'b0));
        step(e_pre(1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 5; k++) add(1'b0, 1'b1, 1'(k % 2), 4'd5, 1'b1, e_pre(1'b0, 1'b0, 1'b0));
        step(e_pre(1'b0, 1'b0, 1'b0));
        step(e_pre(1'b0, 1'b0, 1'b1));
        step(e_gap(1'b0));
        step(e_gap(1'b0));
        step(e_idle(1'b0, 1'b1));
        add(1'b0, 1'b1, 1'b1, 4'd2, 1'b1, e_idle(1'b0, 1'b0));
        step(e_idle(1'b0, 1'b0));
        step(e_idle(1'b0, 1'b0));

        #12;
        check_vec("reset_state", outs(), e_idle(1'b0, 1'b0));
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].en, vq[i].rdy, vq[i].st, vq[i].ns, vq[i].md);
            @(posedge clock);
            #1;
            check_vec($sformatf("vec%0d", i), outs(), vq[i].exp);
        end
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);

        // Reset in DATA at sym_idx=1 with a frame pending
        drive(1'b1, 1'b1, 1'b1, 4'd2, 1'b1);
        @(posedge clock);
        #1;
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
        @(posedge clock);
        #1;
        drive(1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
        @(posedge clock);
        #1;
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
        reached = 0;
        for (int c = 0; c < 20 && reached == 0; c++) begin
            @(posedge clock);
            #1;
            if (bus.ofdm_en && bus.sym_idx == 4'd1) reached = 1;
        end
        check_int("reach_sym1", reached, 1);
        reset = 1'b1;
        #1;
        check_vec("reset_async", outs(), e_idle(1'b0, 1'b0));
        @(posedge clock);
        #1;
        check_vec("reset_hold", outs(), e_idle(1'b0, 1'b0));
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            check_vec($sformatf("no_restart%0d", c), outs(), e_idle(1'b0, 1'b0));
        end

        // Largest symbol count: 15 symbols, no wrap of the symbol counter
        drive(1'b1, 1'b1, 1'b1, 4'd15, 1'b0);
        @(posedge clock);
        #1;
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
        data_cnt  = 0;
        eop_cnt   = 0;
        max_idx   = 0;
        done_seen = 0;
        for (int c = 0; c < 200 && done_seen == 0; c++) begin
            if (bus.ofdm_en) begin
                data_cnt++;
                if (int'(bus.sym_idx) > max_idx) max_idx = int'(bus.sym_idx);
            end
            if (bus.eop) eop_cnt++;
            @(posedge clock);
            #1;
            if (bus.frame_done) done_seen = 1;
        end
        check_int("max_done", done_seen, 1);
        check_int("max_data_cnt", data_cnt, 45);
        check_int("max_sym_idx", max_idx, 14);
        check_int("max_eop_cnt", eop_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Frame-level controller for the transmit chain: decides when a frame starts, the preamble/OFDM sample windows, and the inter-frame gap.
- Drives the enables and the output-mux select for the preamble and OFDM symbol generators.
- Emits frame delimiters `sop`/`eop`.
- Replaces the free-running frame counter with a start-triggered, length-programmable scheduler; modulation changes are latched only at frame boundaries.

Parameters:
- PREAMB_LEN, 320, preamble length in samples (>=2)
- SYM_LEN, 80, OFDM symbol length in samples including CP (>=2)
- GAP_LEN, 16, idle samples after each frame (>=1)
- NSYM_W, 8, width of the data-symbol count

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  global clock-enable; when low, nothing advances
- ready_in  in  1  downstream accepts a sample this cycle
- start  in  1  frame request, one-cycle pulse
- num_sym  in  NSYM_W  OFDM data symbols in the requested frame; sampled with start
- mod_switch_in  in  1  requested modulation
- busy  out  1  frame (incl. gap) in progress
- preamb_en  out  1  enable to preamble generator
- ofdm_en  out  1  enable to OFDM generator
- sel_preamb  out  1  output mux select, 1 = preamble samples
- mod_switch_out  out  1  modulation latched for the current frame
- sym_idx  out  NSYM_W  index of current data symbol
- sop  out  1  first sample of frame
- eop  out  1  last sample of frame
- frame_done  out  1  one-cycle pulse at end of gap

Behaviour:
- Advance condition: `adv = enable & ready_in`. State and counters change only on `adv`, except start/pending capture, which needs only `enable`.
- All outputs are decoded from registers only; there is no combinational input-to-output path.
- Reset values:
  - state = IDLE; `smp_cnt`, `sym_cnt`, `pending` = 0.
  - `mod_switch_out` = 0.
  - All outputs 0, except `sel_preamb` = 1.
- State machine (IDLE, PREAMB, DATA, GAP):
  - IDLE: on `enable & (start | pending)` -> PREAMB.
    - Latch `num_sym` and `mod_switch_in` (from the pending copy if pending).
    - Clear `smp_cnt` and `pending`.
  - PREAMB: `preamb_en` = 1, `sel_preamb` = 1. `smp_cnt` counts on `adv`.
    - At `smp_cnt == PREAMB_LEN-1` with `adv`: go to DATA if latched `num_sym != 0`, else GAP. `smp_cnt` <- 0.
  - DATA: `ofdm_en` = 1, `sel_preamb` = 0, `sym_idx` = `sym_cnt`.
    - At `smp_cnt == SYM_LEN-1` with `adv`: `smp_cnt` <- 0 and `sym_cnt` increments.
    - When `sym_cnt == num_sym-1` at that point: -> GAP, `sym_cnt` <- 0.
  - GAP: all enables 0, `sel_preamb` held 1. Counts GAP_LEN advances.
    - Last gap advance -> IDLE and pulses `frame_done` (registered, high exactly one cycle).
- `sop` is high while state == PREAMB and `smp_cnt` == 0. It is a level and holds across `ready_in` stalls.
- `eop` is high on the last sample of the frame, holding across stalls:
  - DATA with `sym_cnt == num_sym-1` and `smp_cnt == SYM_LEN-1`; or
  - PREAMB with `smp_cnt == PREAMB_LEN-1` when `num_sym == 0`.
- `busy` = (state != IDLE).
- start arriving while busy:
  - Sets `pending` and stores `num_sym`/`mod_switch_in` in a shadow register. A later start overwrites the shadow (one-deep).
  - The pending frame begins on the cycle after IDLE is re-entered. `frame_done` and the new `busy` therefore never overlap in the same cycle.
- start in IDLE while `enable` = 0 is ignored.
- `mod_switch_out` changes only on the IDLE->PREAMB transition. Mid-frame `mod_switch_in` changes have no effect on the current frame.
- Counter widths:
  - `smp_cnt`: `$clog2(max(PREAMB_LEN, SYM_LEN, GAP_LEN))`.
  - `sym_cnt`: NSYM_W. `num_sym` = 2^NSYM_W-1 must work without wrap.
- Reset mid-frame: immediate return to the reset values above. `pending` is lost.

Decomposition:
- Package `frame_pkg`:
  - state enum: IDLE=2'd0, PREAMB=2'd1, DATA=2'd2, GAP=2'd3;
  - default length constants PREAMB_LEN/SYM_LEN/GAP_LEN;
  - `max3` function for the counter width.
- One sub-module, `stall_counter`: a parameterised modulo-N counter with advance and clear, returning terminal-count. It is instantiated for `smp_cnt`; `sym_cnt` stays inline.

Test Plan (bench overrides PREAMB_LEN=4, SYM_LEN=3, GAP_LEN=2, NSYM_W=4):
- Nominal frame: `ready_in` = `enable` = 1, start with `num_sym=2`.
  - 4 cycles `sel_preamb=1`/`preamb_en=1`, `sop` on the 1st.
  - Then 6 cycles `ofdm_en=1` with `sym_idx` 0,0,0,1,1,1, `eop` on the 6th.
  - Then 2 gap cycles; `frame_done` one cycle later; `busy` low after.
- Stalls: `ready_in` toggles 1,0,0,1,... during DATA.
  - `smp_cnt`/`sym_idx` freeze on 0 cycles.
  - Total DATA advances still 6; `eop` holds through a stall on the last sample.
- Preamble-only: start with `num_sym=0`.
  - PREAMB 4 samples, with `sop` on the first and `eop` on the 4th.
  - Then GAP. `ofdm_en` never asserts.
- Start while busy: start(`num_sym=1`, mod=0), then during DATA start(`num_sym=3`, mod=1).
  - The second frame begins the cycle after IDLE with 9 DATA samples.
  - `mod_switch_out` rises only at that second frame's PREAMB entry.
- Reset in DATA at `sym_idx=1`.
  - Next cycle: all outputs at reset values; no pending frame restarts.
- `enable=0` for 5 cycles mid-PREAMB: no state or counter change, and `start` pulses during this window are ignored.
